ctrl_pipe: RTL and testbench

//  Carries decode-stage control (from the decoder) through the E, M and W

---
 rtl/riscv_pkg.sv | 45 ++++
 rtl/ctrl_stage_reg.sv | 30 +++
 rtl/ctrl_pipe.sv | 117 +++++++++++
 tb/tb_ctrl_pipe.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Control encodings and per-stage control bundles shared by the RV32I pipeline.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package riscv_pkg;

   // Writeback mux select encodings
   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   // ALU operation codes driven by the decoder
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // Branch condition selects (instr[14:12])
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   // Everything the E stage needs; an all-zero value is a bubble.
   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic       jump;
      logic       branch;
      logic [2:0] alu_control;
      logic       alu_src;
      logic [2:0] funct3;
   } ctrl_e_t;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
   } ctrl_m_t;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
   } ctrl_w_t;

endpackage

// File: rtl/ctrl_stage_reg.sv
// Generic pipeline register of any type with synchronous reset and clear.
// Latency: 1 cycle; reset and clear both load all-zero (a bubble).
// Backpressure: none, advances every cycle.
// Ports: clk, reset (sync, active-high), clear (sync bubble load),
//        d_i (next-stage value), q_o (registered value).
module ctrl_stage_reg #(
   parameter type T = logic
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  T     d_i,
   output T     q_o
);

   T data_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= '0;
      end else if (clear) begin
         data_q <= '0;
      end else begin
         data_q <= d_i;
      end
   end

   assign q_o = data_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Carries decoder control through E/M/W registers and resolves branches in E.
// Latency: D->E 1 edge, D->M 2, D->W 3; PCSrcE combinational on E regs.
// Backpressure: none; only FlushE (bubble into E) and reset alter flow.
// Ports: clk/reset; FlushE from hazard unit; *D decoder controls and RdD;
//        ZeroE from ALU; E/M/W control and Rd outputs to ALU, memory,
//        register file and hazard unit; PCSrcE to fetch.
module ctrl_pipe
   import riscv_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter bit BNE_EN = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              FlushE,
   input  logic              RegWriteD,
   input  logic [1:0]        ResultSrcD,
   input  logic              MemWriteD,
   input  logic              JumpD,
   input  logic              BranchD,
   input  logic [2:0]        ALUControlD,
   input  logic              ALUSrcD,
   input  logic [2:0]        funct3D,
   input  logic [REG_AW-1:0] RdD,
   input  logic              ZeroE,
   output logic [2:0]        ALUControlE,
   output logic              ALUSrcE,
   output logic              PCSrcE,
   output logic              ResultSrcE0,
   output logic [REG_AW-1:0] RdE,
   output logic              RegWriteM,
   output logic              MemWriteM,
   output logic [REG_AW-1:0] RdM,
   output logic              RegWriteW,
   output logic [1:0]        ResultSrcW,
   output logic [REG_AW-1:0] RdW
);

   ctrl_e_t           ctrl_e_d, ctrl_e_q;
   ctrl_m_t           ctrl_m_d, ctrl_m_q;
   ctrl_w_t           ctrl_w_d, ctrl_w_q;
   logic [REG_AW-1:0] rd_e_q, rd_m_q, rd_w_q;
   logic              taken_e;

   always_comb begin
      ctrl_e_d             = '0;
      ctrl_e_d.reg_write   = RegWriteD;
      ctrl_e_d.result_src  = ResultSrcD;
      ctrl_e_d.mem_write   = MemWriteD;
      ctrl_e_d.jump        = JumpD;
      ctrl_e_d.branch      = BranchD;
      ctrl_e_d.alu_control = ALUControlD;
      ctrl_e_d.alu_src     = ALUSrcD;
      ctrl_e_d.funct3      = funct3D;
   end

   always_comb begin
      ctrl_m_d            = '0;
      ctrl_m_d.reg_write  = ctrl_e_q.reg_write;
      ctrl_m_d.result_src = ctrl_e_q.result_src;
      ctrl_m_d.mem_write  = ctrl_e_q.mem_write;
   end

   always_comb begin
      ctrl_w_d            = '0;
      ctrl_w_d.reg_write  = ctrl_m_q.reg_write;
      ctrl_w_d.result_src = ctrl_m_q.result_src;
   end

   // Only the D->E register honours FlushE; later stages always advance.
   ctrl_stage_reg #(.T(ctrl_e_t)) u_ctrl_e (
      .clk(clk), .reset(reset), .clear(FlushE), .d_i(ctrl_e_d), .q_o(ctrl_e_q)
   );
   ctrl_stage_reg #(.T(ctrl_m_t)) u_ctrl_m (
      .clk(clk), .reset(reset), .clear(1'b0), .d_i(ctrl_m_d), .q_o(ctrl_m_q)
   );
   ctrl_stage_reg #(.T(ctrl_w_t)) u_ctrl_w (
      .clk(clk), .reset(reset), .clear(1'b0), .d_i(ctrl_w_d), .q_o(ctrl_w_q)
   );

   // Rd travels in its own registers so its width can follow REG_AW.
   ctrl_stage_reg #(.T(logic [REG_AW-1:0])) u_rd_e (
      .clk(clk), .reset(reset), .clear(FlushE), .d_i(RdD), .q_o(rd_e_q)
   );
   ctrl_stage_reg #(.T(logic [REG_AW-1:0])) u_rd_m (
      .clk(clk), .reset(reset), .clear(1'b0), .d_i(rd_e_q), .q_o(rd_m_q)
   );
   ctrl_stage_reg #(.T(logic [REG_AW-1:0])) u_rd_w (
      .clk(clk), .reset(reset), .clear(1'b0), .d_i(rd_m_q), .q_o(rd_w_q)
   );

   // ZeroE is only looked at for a real branch, so an unknown ALU flag
   // behind a bubble or non-branch cannot leak into PCSrcE.
   always_comb begin
      taken_e = 1'b0;
      if (ctrl_e_q.branch) begin
         case (ctrl_e_q.funct3)
            F3_BEQ:  taken_e = ZeroE;
            F3_BNE:  taken_e = BNE_EN ? ~ZeroE : 1'b0;
            default: taken_e = 1'b0;
         endcase
      end
   end

   assign PCSrcE      = ctrl_e_q.jump | taken_e;
   assign ALUControlE = ctrl_e_q.alu_control;
   assign ALUSrcE     = ctrl_e_q.alu_src;
   assign ResultSrcE0 = ctrl_e_q.result_src[0];
   assign RdE         = rd_e_q;
   assign RegWriteM   = ctrl_m_q.reg_write;
   assign MemWriteM   = ctrl_m_q.mem_write;
   assign RdM         = rd_m_q;
   assign RegWriteW   = ctrl_w_q.reg_write;
   assign ResultSrcW  = ctrl_w_q.result_src;
   assign RdW         = rd_w_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed literal checks plus a random
// phase compared every cycle against a three-slot history model.
module tb_ctrl_pipe;

   logic       clk = 1'b0;
   logic       reset, FlushE, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ZeroE;
   logic [1:0] ResultSrcD;
   logic [2:0] ALUControlD, funct3D;
   logic [4:0] RdD;
   logic [2:0] ALUControlE;
   logic       ALUSrcE, PCSrcE, ResultSrcE0, RegWriteM, MemWriteM, RegWriteW;
   logic [4:0] RdE, RdM, RdW;
   logic [1:0] ResultSrcW;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   ctrl_pipe #(.REG_AW(5), .BNE_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .FlushE(FlushE),
      .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
      .JumpD(JumpD), .BranchD(BranchD), .ALUControlD(ALUControlD),
      .ALUSrcD(ALUSrcD), .funct3D(funct3D), .RdD(RdD), .ZeroE(ZeroE),
      .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .PCSrcE(PCSrcE),
      .ResultSrcE0(ResultSrcE0), .RdE(RdE), .RegWriteM(RegWriteM),
      .MemWriteM(MemWriteM), .RdM(RdM), .RegWriteW(RegWriteW),
      .ResultSrcW(ResultSrcW), .RdW(RdW)
   );

   // One decoded instruction as the model sees it.
   typedef struct packed {
      logic       rw;
      logic [1:0] rs;
      logic       mw;
      logic       j;
      logic       b;
      logic [2:0] alu;
      logic       as;
      logic [2:0] f3;
      logic [4:0] rd;
   } instr_t;

   // hist[0] is the instruction in E, hist[1] in M, hist[2] in W.
   instr_t hist [3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic exp_pcsrc(input instr_t e, input logic z);
      logic taken;
      if (e.f3 == 3'd0)      taken = z;
      else if (e.f3 == 3'd1) taken = !z;
      else                   taken = 1'b0;
      return e.j || (e.b && taken);
   endfunction

   function automatic instr_t d_now();
      instr_t r;
      r.rw = RegWriteD; r.rs = ResultSrcD; r.mw = MemWriteD; r.j = JumpD;
      r.b = BranchD; r.alu = ALUControlD; r.as = ALUSrcD; r.f3 = funct3D; r.rd = RdD;
      return r;
   endfunction

   // Model: every edge the history shifts by one; reset empties it, a flush
   // puts an empty slot into E instead of the decoded instruction.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) hist[i] = '0;
      end else begin
         hist[2] = hist[1];
         hist[1] = hist[0];
         hist[0] = FlushE ? instr_t'('0) : d_now();
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("ALUControlE", 32'(ALUControlE), 32'(hist[0].alu));
         chk("ALUSrcE",     32'(ALUSrcE),     32'(hist[0].as));
         chk("PCSrcE",      32'(PCSrcE),      32'(exp_pcsrc(hist[0], ZeroE)));
         chk("ResultSrcE0", 32'(ResultSrcE0), 32'(hist[0].rs[0]));
         chk("RdE",         32'(RdE),         32'(hist[0].rd));
         chk("RegWriteM",   32'(RegWriteM),   32'(hist[1].rw));
         chk("MemWriteM",   32'(MemWriteM),   32'(hist[1].mw));
         chk("RdM",         32'(RdM),         32'(hist[1].rd));
         chk("RegWriteW",   32'(RegWriteW),   32'(hist[2].rw));
         chk("ResultSrcW",  32'(ResultSrcW),  32'(hist[2].rs));
         chk("RdW",         32'(RdW),         32'(hist[2].rd));
      end
   end

   task automatic clr_d();
      RegWriteD = 0; ResultSrcD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0;
      ALUControlD = 0; ALUSrcD = 0; funct3D = 0; RdD = 0;
   endtask

   task automatic rand_d();
      RegWriteD = 1'($urandom); ResultSrcD = 2'($urandom_range(0, 2));
      MemWriteD = 1'($urandom); JumpD = 1'($urandom_range(0, 3) == 0);
      BranchD = 1'($urandom); ALUControlD = 3'($urandom);
      ALUSrcD = 1'($urandom); funct3D = 3'($urandom_range(0, 5));
      RdD = 5'($urandom_range(0, 31));
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      FlushE = 0; ZeroE = 0; clr_d();

      // 1: reset over two edges with random D inputs
      reset = 1; rand_d(); ZeroE = 1'($urandom);
      tick(); rand_d();
      tick();
      cmp_en = 1'b1;
      chk("rst_PCSrcE", 32'(PCSrcE), 32'd0);
      chk("rst_RdE", 32'(RdE), 32'd0);
      chk("rst_RegWriteM", 32'(RegWriteM), 32'd0);
      chk("rst_MemWriteM", 32'(MemWriteM), 32'd0);
      chk("rst_RegWriteW", 32'(RegWriteW), 32'd0);
      chk("rst_RdW", 32'(RdW), 32'd0);
      reset = 0; clr_d();

      // 2: add x5
      RegWriteD = 1; ResultSrcD = 2'b00; RdD = 5'd5;
      tick(); clr_d();
      chk("add_RdE", 32'(RdE), 32'd5);
      tick();
      chk("add_RegWriteM", 32'(RegWriteM), 32'd1);
      chk("add_RdM", 32'(RdM), 32'd5);
      tick();
      chk("add_RegWriteW", 32'(RegWriteW), 32'd1);
      chk("add_ResultSrcW", 32'(ResultSrcW), 32'd0);
      chk("add_RdW", 32'(RdW), 32'd5);

      // 3: beq / bne / unsupported funct3
      BranchD = 1; funct3D = 3'b000;
      tick(); clr_d();
      ZeroE = 1; #1 chk("beq_taken", 32'(PCSrcE), 32'd1);
      ZeroE = 0; #1 chk("beq_not_taken", 32'(PCSrcE), 32'd0);
      BranchD = 1; funct3D = 3'b001;
      tick(); clr_d();
      ZeroE = 0; #1 chk("bne_taken", 32'(PCSrcE), 32'd1);
      ZeroE = 1; #1 chk("bne_not_taken", 32'(PCSrcE), 32'd0);
      BranchD = 1; funct3D = 3'b100;
      tick(); clr_d();
      ZeroE = 0; #1 chk("f3_100_z0", 32'(PCSrcE), 32'd0);
      ZeroE = 1; #1 chk("f3_100_z1", 32'(PCSrcE), 32'd0);

      // 4: jal x1
      JumpD = 1; RegWriteD = 1; ResultSrcD = 2'b10; RdD = 5'd1;
      tick(); clr_d();
      chk("jal_PCSrcE", 32'(PCSrcE), 32'd1);
      tick();
      tick();
      chk("jal_ResultSrcW", 32'(ResultSrcW), 32'd2);
      chk("jal_RdW", 32'(RdW), 32'd1);
      chk("jal_RegWriteW", 32'(RegWriteW), 32'd1);

      // 5: store A enters E, then store B flushed on the next edge
      MemWriteD = 1; RdD = 5'd9;
      tick();
      FlushE = 1;
      tick(); FlushE = 0; clr_d();
      chk("flush_A_reaches_M", 32'(MemWriteM), 32'd1);
      chk("flush_E_bubble_Rd", 32'(RdE), 32'd0);
      tick();
      chk("flush_B_MemWriteM", 32'(MemWriteM), 32'd0);

      // 6: lw x7, then reset while it sits in M
      RegWriteD = 1; ResultSrcD = 2'b01; RdD = 5'd7;
      tick(); clr_d();
      chk("lw_ResultSrcE0", 32'(ResultSrcE0), 32'd1);
      tick();
      chk("lw_RegWriteM", 32'(RegWriteM), 32'd1);
      reset = 1;
      tick(); reset = 0;
      chk("lw_reset_RegWriteW", 32'(RegWriteW), 32'd0);
      chk("lw_reset_RdW", 32'(RdW), 32'd0);

      // Random traffic with occasional flushes and resets
      for (int n = 0; n < 3000; n++) begin
         rand_d();
         FlushE = 1'($urandom_range(0, 3) == 0);
         reset  = 1'($urandom_range(0, 49) == 0);
         ZeroE  = 1'($urandom);
         tick();
      end
      reset = 0; FlushE = 0; clr_d();
      tick();
      @(negedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
